serial_demux_ctrl: RTL and testbench

Parametrised serial frame receiver and port demultiplexer. It watches an idle-high serial line, captures a start bit, an address field and a data field, and checks a stop bit. On a good frame it presents the address and data on output registers and pulses exactly one per-port valid line. It sits between the serial input pin and the downstream per-port sinks, and generalises the fixed-length port/data controller to arbitrary field widths, N decoded ports and error reporting.

---
 rtl/serial_demux_pkg.sv | 29 ++
 rtl/serial_demux_ctrl_shreg.sv | 48 ++++
 rtl/serial_demux_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_serial_demux_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_demux_pkg.sv
// -----------------------------------------------------------------------------
// serial_demux_pkg
// Shared definitions for the serial frame receiver / port demultiplexer.
//   state_t   : receiver FSM state encoding
//   FRAME_OVH : non-payload bits per frame (start + stop, plus parity when
//               FRAME_PARITY_EN is defined)
// Optional feature macro: FRAME_PARITY_EN
// -----------------------------------------------------------------------------
package serial_demux_pkg;

`ifdef FRAME_PARITY_EN
    localparam int FRAME_OVH = 3;
`else
    localparam int FRAME_OVH = 2;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
`ifdef FRAME_PARITY_EN
        ,
        PAR     = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/serial_demux_ctrl_shreg.sv
// -----------------------------------------------------------------------------
// serial_shreg
// MSB-first shift register: each enabled cycle the register moves one place
// towards the MSB and din enters at bit 0, so after W shifts the first bit
// received sits in the MSB.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear (wins over shift_en)
//   shift_en  : shift din in this cycle
//   din       : serial input bit
//   q         : parallel contents
// -----------------------------------------------------------------------------
module serial_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] q
);

    logic [W-1:0] next_q_s;

    // A one-bit register has no upper bits to carry along.
    generate
        if (W == 1) begin : g_w1
            assign next_q_s = din;
        end else begin : g_wn
            assign next_q_s = {q[W-2:0], din};
        end
    endgenerate

    // Shift register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (shift_en) begin
            q <= next_q_s;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/serial_demux_ctrl.sv
// -----------------------------------------------------------------------------
// serial_demux_ctrl
// Receives frames on an idle-high serial line, MSB first:
//   start(0), ADDR_W address bits, DATA_W data bits, [even parity], stop(1)
// and on a good frame loads addr/data and pulses port_valid[addr] for one cycle.
// A bad frame pulses frame_err and leaves addr/data untouched. After a low
// stop bit the receiver waits for the line to return high before re-arming.
// Optional feature macro: FRAME_PARITY_EN (adds one even-parity bit).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   serial_in    : serial line, one bit per clock
//   serial_out   : serial_in delayed by one cycle
//   port_enable  : high while address bits are captured
//   smbs_enable  : high while data bits are captured
//   busy         : high whenever the receiver is not idle
//   addr, data   : fields of the last good frame
//   port_valid   : one-hot, one-cycle good-frame strobe
//   frame_err    : one-cycle bad-frame strobe
// -----------------------------------------------------------------------------
module serial_demux_ctrl
    import serial_demux_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    localparam int NPORTS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic              serial_out,
    output logic              port_enable,
    output logic              smbs_enable,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic [NPORTS-1:0] port_valid,
    output logic              frame_err
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [NPORTS-1:0] PV_ONE    = NPORTS'(1);

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               sh_clr_s;
    logic               addr_shift_s;
    logic               data_shift_s;
    logic               load_s;
    logic               err_s;
    logic               par_err_s;
    logic [ADDR_W-1:0]  addr_sh_s;
    logic [DATA_W-1:0]  data_sh_s;

    serial_shreg #(.W(ADDR_W)) u_addr_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (sh_clr_s),
        .shift_en (addr_shift_s),
        .din      (serial_in),
        .q        (addr_sh_s)
    );

    serial_shreg #(.W(DATA_W)) u_data_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (sh_clr_s),
        .shift_en (data_shift_s),
        .din      (serial_in),
        .q        (data_sh_s)
    );

`ifdef FRAME_PARITY_EN
    logic par_chk_s;
    logic par_err_r;

    // Even parity: the ones over address, data and parity bit must be even.
    function automatic logic parity_mismatch(input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] d,
                                             input logic p);
        return ^{a, d, p};
    endfunction

    // Latch the parity verdict at the parity bit; re-armed at each start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_r <= 1'b0;
        end else if (sh_clr_s) begin
            par_err_r <= 1'b0;
        end else if (par_chk_s) begin
            par_err_r <= parity_mismatch(addr_sh_s, data_sh_s, serial_in);
        end else begin
            par_err_r <= par_err_r;
        end
    end

    assign par_err_s = par_err_r;
`else
    assign par_err_s = 1'b0;
`endif

    // FSM state and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        sh_clr_s     = 1'b0;
        addr_shift_s = 1'b0;
        data_shift_s = 1'b0;
        load_s       = 1'b0;
        err_s        = 1'b0;
`ifdef FRAME_PARITY_EN
        par_chk_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (serial_in == 1'b0) begin
                    next_state_s = ADDR;
                    cnt_next_s   = CNT_ZERO;
                    sh_clr_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ADDR: begin
                addr_shift_s = 1'b1;
                if (cnt_r == ADDR_LAST) begin
                    next_state_s = DATA;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                data_shift_s = 1'b1;
                if (cnt_r == DATA_LAST) begin
`ifdef FRAME_PARITY_EN
                    next_state_s = PAR;
`else
                    next_state_s = STOP;
`endif
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
`ifdef FRAME_PARITY_EN
            PAR: begin
                par_chk_s    = 1'b1;
                next_state_s = STOP;
                cnt_next_s   = CNT_ZERO;
            end
`endif
            STOP: begin
                cnt_next_s = CNT_ZERO;
                if (serial_in && !par_err_s) begin
                    load_s = 1'b1;
                end else begin
                    err_s  = 1'b1;
                end
                // A low stop bit must not be mistaken for the next start bit.
                if (serial_in) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (serial_in) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_HI;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Output registers; enables are registered copies of the next-state
    // decode so they line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_out  <= 1'b1;
            port_enable <= 1'b0;
            smbs_enable <= 1'b0;
            busy        <= 1'b0;
            addr        <= {ADDR_W{1'b0}};
            data        <= {DATA_W{1'b0}};
            port_valid  <= {NPORTS{1'b0}};
            frame_err   <= 1'b0;
        end else begin
            serial_out  <= serial_in;
            port_enable <= (next_state_s == ADDR);
            smbs_enable <= (next_state_s == DATA);
            busy        <= (next_state_s != IDLE);
            frame_err   <= err_s;
            if (load_s) begin
                addr       <= addr_sh_s;
                data       <= data_sh_s;
                port_valid <= PV_ONE << addr_sh_s;
            end else begin
                addr       <= addr;
                data       <= data;
                port_valid <= {NPORTS{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_serial_demux_ctrl.sv
// Self-checking bench for serial_demux_ctrl: directed scenarios plus random
// frames, checked against a frame-level reference model.
module tb_serial_demux_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam int NPORTS = 2 ** ADDR_W;

    logic              clk;
    logic              rst;
    logic              serial_in;
    logic              serial_out;
    logic              port_enable;
    logic              smbs_enable;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [NPORTS-1:0] port_valid;
    logic              frame_err;

    int n_tests;
    int n_fail;

    // Reference model: fields of the last good frame.
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    serial_demux_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .serial_out  (serial_out),
        .port_enable (port_enable),
        .smbs_enable (smbs_enable),
        .busy        (busy),
        .addr        (addr),
        .data        (data),
        .port_valid  (port_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends one frame starting at the current negedge and checks it.
    task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic par_ok, input logic stop_b, input string name);
        logic bits[$];
        int pe_cnt, se_cnt, busy_cnt, stray, echo_bad;
        logic good;
        logic [NPORTS-1:0] exp_pv;
        int nb;
        pe_cnt = 0; se_cnt = 0; busy_cnt = 0; stray = 0; echo_bad = 0;
        bits.push_back(1'b0);
        for (int i = ADDR_W - 1; i >= 0; i--) bits.push_back(a[i]);
        for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(d[i]);
`ifdef FRAME_PARITY_EN
        bits.push_back((^{a, d}) ^ !par_ok);
        good = stop_b && par_ok;
`else
        good = stop_b;
        if (!par_ok) good = stop_b;
`endif
        bits.push_back(stop_b);
        nb = bits.size();
        for (int i = 0; i < nb; i++) begin
            serial_in = bits[i];
            @(negedge clk);
            if (serial_out !== bits[i]) echo_bad++;
            if (i < nb - 1) begin
                pe_cnt   += int'(port_enable);
                se_cnt   += int'(smbs_enable);
                busy_cnt += int'(busy);
                if (port_valid !== '0 || frame_err !== 1'b0) stray++;
            end
        end
        if (good) begin
            exp_addr = a;
            exp_data = d;
            exp_pv   = NPORTS'(1) << a;
        end else begin
            exp_pv   = '0;
        end
        n_tests++; if (echo_bad !== 0)          begin n_fail++; $display("FAIL %s echo: %0d bad bits, need 0", name, echo_bad); end
        n_tests++; if (pe_cnt !== ADDR_W)       begin n_fail++; $display("FAIL %s port_enable cycles: got %0d need %0d", name, pe_cnt, ADDR_W); end
        n_tests++; if (se_cnt !== DATA_W)       begin n_fail++; $display("FAIL %s smbs_enable cycles: got %0d need %0d", name, se_cnt, DATA_W); end
        n_tests++; if (busy_cnt !== nb - 1)     begin n_fail++; $display("FAIL %s busy cycles: got %0d need %0d", name, busy_cnt, nb - 1); end
        n_tests++; if (stray !== 0)             begin n_fail++; $display("FAIL %s early pulses: %0d", name, stray); end
        n_tests++; if (port_valid !== exp_pv)   begin n_fail++; $display("FAIL %s port_valid: got %b need %b", name, port_valid, exp_pv); end
        n_tests++; if (frame_err !== !good)     begin n_fail++; $display("FAIL %s frame_err: got %b need %b", name, frame_err, !good); end
        n_tests++; if (addr !== exp_addr)       begin n_fail++; $display("FAIL %s addr: got %h need %h", name, addr, exp_addr); end
        n_tests++; if (data !== exp_data)       begin n_fail++; $display("FAIL %s data: got %h need %h", name, data, exp_data); end
        n_tests++; if (busy !== !stop_b)        begin n_fail++; $display("FAIL %s busy after stop: got %b need %b", name, busy, !stop_b); end
    endtask

    // Holds the line at level for n cycles; nothing may start or pulse.
    task automatic line_hold(input logic level, input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            serial_in = level;
            @(negedge clk);
            if (port_valid !== '0 || frame_err !== 1'b0 || port_enable !== 1'b0 ||
                smbs_enable !== 1'b0 || busy !== !level || addr !== exp_addr || data !== exp_data)
                bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad cycles with line=%b, need 0", name, bad, level);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; serial_in = 1'b1;
        exp_addr = '0; exp_data = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({serial_out, port_enable, smbs_enable, busy, addr, data, port_valid, frame_err} !==
            {1'b1, 1'b0, 1'b0, 1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, {NPORTS{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL reset values: so=%b pe=%b se=%b busy=%b addr=%h data=%h pv=%b fe=%b, need 1,0,0,0,0,0,0,0",
                     serial_out, port_enable, smbs_enable, busy, addr, data, port_valid, frame_err);
        end
        rst = 1'b0;
        line_hold(1'b1, 20, "post-reset idle");
    endtask

    task automatic test_good_frame();
        send_frame(2'b10, 8'hA5, 1'b1, 1'b1, "good A5");
        line_hold(1'b1, 2, "idle after good");
    endtask

    task automatic test_bad_stop();
        send_frame(2'b01, 8'h5A, 1'b1, 1'b0, "bad stop");
        line_hold(1'b0, 5, "held low");
        line_hold(1'b1, 2, "recover high");
    endtask

    task automatic test_back_to_back();
        send_frame(2'd0, 8'h01, 1'b1, 1'b1, "b2b first");
        send_frame(2'd3, 8'hFF, 1'b1, 1'b1, "b2b second");
        line_hold(1'b1, 1, "idle after b2b");
    endtask

    task automatic test_midframe_reset();
        logic bits[$];
        bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < bits.size(); i++) begin
            serial_in = bits[i];
            @(negedge clk);
        end
        #2;
        rst = 1'b1; serial_in = 1'b1;
        exp_addr = '0; exp_data = '0;
        #1;
        n_tests++;
        if ({busy, smbs_enable, port_enable, addr, data, port_valid, frame_err, serial_out} !==
            {1'b0, 1'b0, 1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, {NPORTS{1'b0}}, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midframe reset: busy=%b se=%b pe=%b addr=%h data=%h pv=%b fe=%b so=%b, need all clear, so=1",
                     busy, smbs_enable, port_enable, addr, data, port_valid, frame_err, serial_out);
        end
        @(negedge clk);
        rst = 1'b0;
        line_hold(1'b1, 4, "after midframe reset");
        send_frame(2'd1, 8'h3C, 1'b1, 1'b1, "post-reset frame");
        line_hold(1'b1, 1, "idle after post-reset");
    endtask

`ifdef FRAME_PARITY_EN
    task automatic test_parity();
        send_frame(2'd1, 8'h03, 1'b1, 1'b1, "parity good");
        send_frame(2'd1, 8'h03, 1'b0, 1'b1, "parity bad");
        line_hold(1'b1, 1, "idle after parity");
    endtask
`endif

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic p_ok, s_b;
        for (int f = 0; f < 40; f++) begin
            a    = ADDR_W'($urandom_range(NPORTS - 1, 0));
            d    = DATA_W'($urandom);
            p_ok = ($urandom_range(3, 0) != 0);
            s_b  = ($urandom_range(5, 0) != 0);
            send_frame(a, d, p_ok, s_b, "random");
            if (!s_b) begin
                line_hold(1'b0, $urandom_range(3, 0), "random low");
                line_hold(1'b1, 1 + $urandom_range(2, 0), "random recover");
            end else if ($urandom_range(1, 0) == 0) begin
                line_hold(1'b1, 1 + $urandom_range(2, 0), "random gap");
            end else begin
                // back-to-back with the next frame
            end
        end
        line_hold(1'b1, 2, "random end");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        serial_in = 1'b1;
        exp_addr = '0;
        exp_data = '0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_stop();
        test_back_to_back();
        test_midframe_reset();
`ifdef FRAME_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
